// File: rtl/oam_dma_ctrl_if.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl_if
//
// Purpose
//   Bundles the CPU-side bus, the cpu_memory-side bus and the stall handshake
//   of the sprite OAM DMA sequencer. Clock and reset are not part of the bundle.
//
// Signals
//   clock_en    CPU cycle enable; the DMA sequencer only advances when high
//   cpu_addr    CPU-driven address
//   cpu_r_en    CPU read enable (1 = read, 0 = write)
//   cpu_w_data  CPU write data
//   mem_r_data  cpu_memory read data, valid one enabled cycle after the address
//   mem_addr    address presented to cpu_memory
//   mem_r_en    read enable presented to cpu_memory
//   mem_w_data  write data presented to cpu_memory
//   cpu_stall   CPU must hold all of its state while high
//   dma_busy    DMA owns the memory bus (identical to cpu_stall)
//
// Modports
//   master  the DMA sequencer: it masters the memory bus and stalls the CPU
//   slave   the surroundings: CPU core plus cpu_memory
// -----------------------------------------------------------------------------
interface oam_dma_ctrl_if;
    logic        clock_en;
    logic [15:0] cpu_addr;
    logic        cpu_r_en;
    logic [7:0]  cpu_w_data;
    logic [7:0]  mem_r_data;
    logic [15:0] mem_addr;
    logic        mem_r_en;
    logic [7:0]  mem_w_data;
    logic        cpu_stall;
    logic        dma_busy;

    modport master (
        input  clock_en,
        input  cpu_addr,
        input  cpu_r_en,
        input  cpu_w_data,
        input  mem_r_data,
        output mem_addr,
        output mem_r_en,
        output mem_w_data,
        output cpu_stall,
        output dma_busy
    );

    modport slave (
        output clock_en,
        output cpu_addr,
        output cpu_r_en,
        output cpu_w_data,
        output mem_r_data,
        input  mem_addr,
        input  mem_r_en,
        input  mem_w_data,
        input  cpu_stall,
        input  dma_busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// Purpose
//   Sequencer and bus arbiter for sprite OAM DMA, placed between the CPU core
//   and cpu_memory. While idle the CPU bus is passed straight through to
//   memory with no added latency. A CPU write to DMA_REG_ADDR stalls the CPU,
//   hands the memory bus to the sequencer, copies the 256 bytes of page
//   {data, 8'h00} to OAMDATA_ADDR one byte at a time (read, then write), and
//   finally returns the bus. The CPU is stalled for 513 enabled cycles when
//   the trigger falls on an even cycle and 514 when it falls on an odd cycle.
//
// Parameters
//   DMA_REG_ADDR  CPU address whose write starts a transfer
//   OAMDATA_ADDR  destination address written once per byte
//
// Ports
//   clock    system clock
//   reset_n  asynchronous, active-low reset
//   bus      oam_dma_ctrl_if.master: CPU bus in, memory bus out, stall out
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic          clock,
    input  logic          reset_n,
    oam_dma_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMMY,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  idx_q,   idx_d;
    logic        parity_q, parity_d;

    logic [15:0] mem_addr_c;
    logic        mem_r_en_c;
    logic [7:0]  mem_w_data_c;
    logic        trigger;

    // A write to the DMA register is only honoured from IDLE; the state
    // check lives in the FSM below so writes while busy simply fall through.
    assign trigger = bus.clock_en && (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_r_en;

    // -------------------------------------------------------------------------
    // State register. Every flop loads its _d value each clock; the enable
    // gating is folded into the next-state logic so held values stay put.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and bus multiplexing.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        idx_d        = idx_q;
        parity_d     = parity_q;
        mem_addr_c   = bus.cpu_addr;
        mem_r_en_c   = bus.cpu_r_en;
        mem_w_data_c = bus.cpu_w_data;

        // Free-running cycle parity; only the enable stops it.
        if (bus.clock_en) begin
            parity_d = ~parity_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Pass-through, including the trigger cycle itself.
                if (trigger) begin
                    page_d  = bus.cpu_w_data;
                    idx_d   = 8'h00;
                    state_d = ST_DUMMY;
                end
            end

            ST_DUMMY: begin
                // Idle read on whatever address the stalled CPU holds; a
                // held CPU write must not reach memory.
                mem_addr_c   = bus.cpu_addr;
                mem_r_en_c   = 1'b1;
                mem_w_data_c = 8'h00;
                if (bus.clock_en) begin
                    // parity_q here is the inverse of the trigger cycle's
                    // parity: 0 means the trigger was odd and one more
                    // idle cycle is needed so the first READ lands on even.
                    state_d = parity_q ? ST_READ : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                mem_addr_c   = bus.cpu_addr;
                mem_r_en_c   = 1'b1;
                mem_w_data_c = 8'h00;
                if (bus.clock_en) begin
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                mem_addr_c   = {page_q, idx_q};
                mem_r_en_c   = 1'b1;
                mem_w_data_c = 8'h00;
                if (bus.clock_en) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Memory returns the byte addressed in the preceding READ.
                mem_addr_c   = OAMDATA_ADDR;
                mem_r_en_c   = 1'b0;
                mem_w_data_c = bus.mem_r_data;
                if (bus.clock_en) begin
                    idx_d   = idx_q + 8'h01;
                    state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_r_en   = mem_r_en_c;
    assign bus.mem_w_data = mem_w_data_c;

    // Decoded straight from the state register, so the stall rises the cycle
    // after the trigger and falls the cycle after the last WRITE.
    assign bus.cpu_stall  = (state_q != ST_IDLE);
    assign bus.dma_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_ctrl
//
// Bench for oam_dma_ctrl: a byte-wide memory model with registered reads and
// a log of every write to $2004, a table of idle pass-through vectors, and
// hand-written DMA sequences (even/odd start, gated enable, retrigger, reset
// mid-transfer). Inputs change on the falling edge, outputs are sampled 1 ns
// later, the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    oam_dma_ctrl_if bus_if ();

    oam_dma_ctrl #(
        .DMA_REG_ADDR(16'h4014),
        .OAMDATA_ADDR(16'h2004)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_if.master)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- memory model ----------------
    logic [7:0] ram [0:65535];
    logic [7:0] rd_q;
    logic [7:0] oam_log [$];
    logic       par;

    assign bus_if.mem_r_data = rd_q;

    always @(posedge clock) begin
        if (bus_if.clock_en) begin
            if (bus_if.mem_r_en) begin
                rd_q <= ram[bus_if.mem_addr];
            end else if (bus_if.mem_addr == 16'h2004) begin
                oam_log.push_back(bus_if.mem_w_data);
            end else begin
                ram[bus_if.mem_addr] <= bus_if.mem_w_data;
            end
        end
    end

    // Independent model of the cycle parity the design should be tracking.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)               par <= 1'b0;
        else if (bus_if.clock_en)   par <= ~par;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0];
        hi = a[15:8];
        return lo * 8'd37 + hi * 8'd11 + 8'd5;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ce, input logic [15:0] a, input logic r, input logic [7:0] d);
        bus_if.clock_en   = ce;
        bus_if.cpu_addr   = a;
        bus_if.cpu_r_en   = r;
        bus_if.cpu_w_data = d;
    endtask

    // ---------------- idle pass-through table ----------------
    typedef struct {
        logic        ce;
        logic [15:0] addr;
        logic        r_en;
        logic [7:0]  wd;
        logic [15:0] e_addr;
        logic        e_ren;
        logic [7:0]  e_wd;
        logic        e_stall;
    } vec_t;

    vec_t vecs [6];

    // ---------------- DMA sequence ----------------
    // Triggers a transfer of page 'page' on a cycle of parity 'odd'.
    // toggle: clock_en alternates 0/1 during the transfer.
    // retrig: the stalled CPU writes $07 to $4014 part way through.
    // rst_after: if > 0, assert reset once that many bytes have been written.
    task automatic run_dma(input string name, input logic [7:0] page, input logic odd,
                           input logic toggle, input logic retrig, input int rst_after);
        int     cyc;
        int     en_cnt;
        int     wbad;
        int     busy_bad;
        int     bad_bytes;
        int     first_par;
        logic   seen_first;
        logic   timed_out;
        logic   ce;

        en_cnt     = 0;
        wbad       = 0;
        busy_bad   = 0;
        bad_bytes  = 0;
        first_par  = -1;
        seen_first = 1'b0;
        timed_out  = 1'b1;

        @(negedge clock);
        set_in(1'b1, 16'h8123, 1'b1, 8'h00);
        if (par !== odd) @(negedge clock);
        oam_log.delete();

        // Trigger cycle: still a plain pass-through write.
        set_in(1'b1, 16'h4014, 1'b0, page);
        #1;
        check({name, " trig_addr"},  int'(bus_if.mem_addr), 32'h4014);
        check({name, " trig_ren"},   int'(bus_if.mem_r_en), 0);
        check({name, " trig_stall"}, int'(bus_if.cpu_stall), 0);

        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            ce = toggle ? cyc[0] : 1'b1;
            if (retrig && en_cnt == 40) set_in(ce, 16'h4014, 1'b0, 8'h07);
            else                        set_in(ce, 16'h8123, 1'b1, 8'h00);
            #1;
            if (rst_after > 0 && oam_log.size() >= rst_after) begin
                reset_n = 1'b0;
                #1;
                check({name, " rst_stall"}, int'(bus_if.cpu_stall), 0);
                check({name, " rst_busy"},  int'(bus_if.dma_busy), 0);
                timed_out = 1'b0;
                break;
            end
            if (!bus_if.cpu_stall) begin
                timed_out = 1'b0;
                break;
            end
            if (bus_if.dma_busy !== bus_if.cpu_stall) busy_bad++;
            if (ce) en_cnt++;
            if (bus_if.mem_r_en && bus_if.mem_w_data != 8'h00) wbad++;
            if (ce && bus_if.mem_r_en && bus_if.mem_addr == {page, 8'h00} && !seen_first) begin
                seen_first = 1'b1;
                first_par  = int'(par);
            end
        end

        check({name, " timeout"}, int'(timed_out), 0);
        if (rst_after > 0) begin
            $display("dma %s page=%02h reset after %0d bytes", name, page, oam_log.size());
            return;
        end

        check({name, " stall_cycles"}, en_cnt, odd ? 514 : 513);
        check({name, " byte_count"}, oam_log.size(), 256);
        for (int i = 0; i < oam_log.size() && i < 256; i++) begin
            if (oam_log[i] !== pat({page, 8'(i)})) bad_bytes++;
        end
        check({name, " bad_bytes"}, bad_bytes, 0);
        check({name, " wdata_nonzero"}, wbad, 0);
        check({name, " busy_ne_stall"}, busy_bad, 0);
        check({name, " first_read_seen"}, int'(seen_first), 1);
        check({name, " first_read_parity"}, first_par, 0);
        check({name, " post_addr"}, int'(bus_if.mem_addr), 32'h8123);
        check({name, " post_ren"},  int'(bus_if.mem_r_en), 1);
        $display("dma %s page=%02h odd=%0d stall=%0d bytes=%0d bad=%0d",
                 name, page, odd, en_cnt, oam_log.size(), bad_bytes);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h8000, 1'b1, 8'h00, 16'h8000, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 16'h0010, 1'b0, 8'h5A, 16'h0010, 1'b0, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 16'h4014, 1'b1, 8'h33, 16'h4014, 1'b1, 8'h33, 1'b0};
        vecs[3] = '{1'b1, 16'h4015, 1'b0, 8'h77, 16'h4015, 1'b0, 8'h77, 1'b0};
        vecs[4] = '{1'b0, 16'h4014, 1'b0, 8'h09, 16'h4014, 1'b0, 8'h09, 1'b0};
        vecs[5] = '{1'b1, 16'h2004, 1'b0, 8'hC3, 16'h2004, 1'b0, 8'hC3, 1'b0};

        for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));

        // Reset state: pass-through while reset is held.
        set_in(1'b1, 16'h1234, 1'b1, 8'hA5);
        repeat (3) @(negedge clock);
        #1;
        check("reset stall", int'(bus_if.cpu_stall), 0);
        check("reset busy",  int'(bus_if.dma_busy), 0);
        check("reset addr",  int'(bus_if.mem_addr), 32'h1234);
        check("reset ren",   int'(bus_if.mem_r_en), 1);
        check("reset wdata", int'(bus_if.mem_w_data), 32'hA5);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle pass-through vectors.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            set_in(vecs[i].ce, vecs[i].addr, vecs[i].r_en, vecs[i].wd);
            #1;
            check($sformatf("vec%0d addr", i),  int'(bus_if.mem_addr),   int'(vecs[i].e_addr));
            check($sformatf("vec%0d ren", i),   int'(bus_if.mem_r_en),   int'(vecs[i].e_ren));
            check($sformatf("vec%0d wdata", i), int'(bus_if.mem_w_data), int'(vecs[i].e_wd));
            check($sformatf("vec%0d stall", i), int'(bus_if.cpu_stall),  int'(vecs[i].e_stall));
            $display("vec %0d ce=%0d addr=%04h r=%0d wd=%02h -> addr=%04h r=%0d wd=%02h stall=%0d",
                     i, vecs[i].ce, vecs[i].addr, vecs[i].r_en, vecs[i].wd,
                     bus_if.mem_addr, bus_if.mem_r_en, bus_if.mem_w_data, bus_if.cpu_stall);
        end
        @(negedge clock);
        set_in(1'b1, 16'h8123, 1'b1, 8'h00);
        #1;
        check("idle after vectors stall", int'(bus_if.cpu_stall), 0);
        check("idle written ram 0010", int'(ram[16'h0010]), 32'h5A);

        // DMA sequences.
        run_dma("even",    8'h02, 1'b0, 1'b0, 1'b0, 0);
        run_dma("odd",     8'h02, 1'b1, 1'b0, 1'b0, 0);
        run_dma("gated",   8'h02, 1'b0, 1'b1, 1'b0, 0);
        run_dma("retrig",  8'h02, 1'b0, 1'b0, 1'b1, 0);
        run_dma("ppupage", 8'h21, 1'b1, 1'b0, 1'b0, 0);

        // Reset after 100 bytes, then a fresh complete transfer.
        run_dma("reset", 8'h02, 1'b0, 1'b0, 1'b0, 100);
        repeat (2) @(negedge clock);
        #1;
        check("reset held stall", int'(bus_if.cpu_stall), 0);
        check("reset held bytes", oam_log.size(), 100);
        reset_n = 1'b1;
        run_dma("after_reset", 8'h03, 1'b0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
